// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the FFT result readout block.
package fft_pkg;

   localparam int N_POINTS = 64;
   localparam int LOG2N    = $clog2(N_POINTS);
   localparam int DATA_W   = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/no_samples_out_if.sv
// Downstream sample stream. A sample moves when out_valid and out_ready are both
// high at a rising clk edge; once out_valid rises, data and last hold until that edge.
interface no_samples_out_if #(
   parameter int DATA_W = 32
) ();

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/bit_reverse.sv
// Combinational bit-order reversal, used to turn a natural sample index into
// the FFT result memory address.
module bit_reverse #(
   parameter int W = 6
) (
   input  logic [W-1:0] value,
   output logic [W-1:0] reversed
);

   always_comb begin
      reversed = '0;
      for (int i = 0; i < W; i++) begin
         reversed[i] = value[W-1-i];
      end
   end

endmodule

// File: rtl/no_samples_out.sv
// Reads a completed FFT result buffer in bit-reversed address order and streams
// the samples downstream in natural order, one FETCH/PRESENT pair per sample.
module no_samples_out #(
   parameter int N_POINTS = fft_pkg::N_POINTS,
   parameter int DATA_W   = fft_pkg::DATA_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start_strobe,
   input  logic [DATA_W-1:0]            rd_data,
   output logic                         rd_en,
   output logic [$clog2(N_POINTS)-1:0]  rd_addr,
   no_samples_out_if.master             out_if,
   output logic [$clog2(N_POINTS):0]    samples_out_count_out,
   output logic                         busy,
   output logic                         done_strobe,
   output fft_pkg::state_t              state_dbg
);

   localparam int LOG2N = $clog2(N_POINTS);
   localparam int CNT_W = LOG2N + 1;

   fft_pkg::state_t  state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [LOG2N-1:0] fetch_idx;
   logic [LOG2N-1:0] fetch_addr;

   // The address is prepared one step ahead: index 0 on start, count+1 on acceptance.
   assign count_nxt = count + CNT_W'(1);
   assign fetch_idx = (state == fft_pkg::IDLE) ? '0 : count_nxt[LOG2N-1:0];

   bit_reverse #(
      .W(LOG2N)
   ) u_bit_reverse (
      .value    (fetch_idx),
      .reversed (fetch_addr)
   );

   assign samples_out_count_out = count;
   assign state_dbg             = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= fft_pkg::IDLE;
         count            <= '0;
         rd_en            <= 1'b0;
         rd_addr          <= '0;
         out_if.out_valid <= 1'b0;
         out_if.out_data  <= '0;
         out_if.out_last  <= 1'b0;
         busy             <= 1'b0;
         done_strobe      <= 1'b0;
      end else begin
         case (state)
            fft_pkg::IDLE: begin
               done_strobe <= 1'b0;
               if (start_strobe) begin
                  count   <= '0;
                  busy    <= 1'b1;
                  rd_en   <= 1'b1;
                  rd_addr <= fetch_addr;
                  state   <= fft_pkg::FETCH;
               end
            end
            fft_pkg::FETCH: begin
               rd_en            <= 1'b0;
               rd_addr          <= '0;
               out_if.out_data  <= rd_data;
               out_if.out_valid <= 1'b1;
               out_if.out_last  <= (count == CNT_W'(N_POINTS - 1));
               state            <= fft_pkg::PRESENT;
            end
            fft_pkg::PRESENT: begin
               if (out_if.out_ready) begin
                  out_if.out_valid <= 1'b0;
                  out_if.out_last  <= 1'b0;
                  count            <= count_nxt;
                  if (count_nxt == CNT_W'(N_POINTS)) begin
                     busy        <= 1'b0;
                     done_strobe <= 1'b1;
                     state       <= fft_pkg::DONE;
                  end else begin
                     rd_en   <= 1'b1;
                     rd_addr <= fetch_addr;
                     state   <= fft_pkg::FETCH;
                  end
               end
            end
            fft_pkg::DONE: begin
               done_strobe <= 1'b0;
               state       <= fft_pkg::IDLE;
            end
            default: state <= fft_pkg::IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_no_samples_out.sv
// Bench for no_samples_out: fixed vector table, directed corner frames and
// random-backpressure frames checked against a natural-order sample model.
module tb_no_samples_out;
   import fft_pkg::*;

   localparam int CNT_W  = LOG2N + 1;
   localparam int BUDGET = 8 * N_POINTS + 16;

   logic              tb_clk = 1'b0;
   logic              reset;
   logic              start_strobe;
   logic [DATA_W-1:0] rd_data;
   logic              rd_en;
   logic [LOG2N-1:0]  rd_addr;
   logic [CNT_W-1:0]  count;
   logic              busy;
   logic              done_strobe;
   state_t            state_dbg;

   logic [DATA_W-1:0] mem [N_POINTS];
   int n_cmp = 0;
   int n_err = 0;

   no_samples_out_if #(.DATA_W(DATA_W)) out_bus ();

   no_samples_out #(
      .N_POINTS(N_POINTS),
      .DATA_W  (DATA_W)
   ) dut (
      .clk                   (tb_clk),
      .reset                 (reset),
      .start_strobe          (start_strobe),
      .rd_data               (rd_data),
      .rd_en                 (rd_en),
      .rd_addr               (rd_addr),
      .out_if                (out_bus),
      .samples_out_count_out (count),
      .busy                  (busy),
      .done_strobe           (done_strobe),
      .state_dbg             (state_dbg)
   );

   always #5 tb_clk = ~tb_clk;

   // Result memory model: data for the addressed word is available by the end of the read cycle.
   assign rd_data = rd_en ? mem[rd_addr] : DATA_W'(32'hDEAD_BEEF);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int brev(input int k);
      int r = 0;
      int x = k;
      for (int i = 0; i < LOG2N; i++) begin
         r = r * 2 + x % 2;
         x = x / 2;
      end
      return r;
   endfunction

   task automatic fill_mem();
      for (int i = 0; i < N_POINTS; i++) mem[i] = $urandom;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rd_en"},     rd_en, 0);
      check({tag, "_rd_addr"},   rd_addr, 0);
      check({tag, "_out_valid"}, out_bus.out_valid, 0);
      check({tag, "_out_data"},  out_bus.out_data, 0);
      check({tag, "_out_last"},  out_bus.out_last, 0);
      check({tag, "_count"},     count, 0);
      check({tag, "_busy"},      busy, 0);
      check({tag, "_done"},      done_strobe, 0);
      check({tag, "_state"},     state_dbg, IDLE);
   endtask

   // Called just after a rising edge: asserts reset mid-cycle and checks the immediate effect.
   task automatic mid_cycle_reset(input string tag);
      #2 reset = 1'b1;
      #1 check_zero(tag);
      @(posedge tb_clk);
      #1 reset = 1'b0;
   endtask

   typedef struct {
      logic             start;
      logic             ready;
      logic             e_rd_en;
      logic [LOG2N-1:0] e_addr;
      logic             e_valid;
      int               e_idx;
      logic             e_busy;
      logic [CNT_W-1:0] e_count;
   } vec_t;

   task automatic run_table();
      vec_t tv [8];
      tv[0] = '{1'b1, 1'b1, 1'b1, 6'd0,  1'b0, 0, 1'b1, 7'd0};
      tv[1] = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b1, 0, 1'b1, 7'd0};
      tv[2] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 0, 1'b1, 7'd0};
      tv[3] = '{1'b0, 1'b1, 1'b1, 6'd32, 1'b0, 0, 1'b1, 7'd1};
      tv[4] = '{1'b0, 1'b1, 1'b0, 6'd0,  1'b1, 1, 1'b1, 7'd1};
      tv[5] = '{1'b1, 1'b1, 1'b1, 6'd16, 1'b0, 0, 1'b1, 7'd2};
      tv[6] = '{1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 2, 1'b1, 7'd2};
      tv[7] = '{1'b0, 1'b1, 1'b1, 6'd48, 1'b0, 0, 1'b1, 7'd3};
      for (int i = 0; i < 8; i++) begin
         start_strobe      = tv[i].start;
         out_bus.out_ready = tv[i].ready;
         @(posedge tb_clk);
         #1;
         check($sformatf("tv%0d_rd_en", i),  rd_en, tv[i].e_rd_en);
         check($sformatf("tv%0d_rd_addr", i), rd_addr, tv[i].e_addr);
         check($sformatf("tv%0d_valid", i),  out_bus.out_valid, tv[i].e_valid);
         check($sformatf("tv%0d_busy", i),   busy, tv[i].e_busy);
         check($sformatf("tv%0d_count", i),  count, tv[i].e_count);
         if (tv[i].e_valid) check($sformatf("tv%0d_data", i), out_bus.out_data, mem[brev(tv[i].e_idx)]);
      end
      start_strobe      = 1'b0;
      out_bus.out_ready = 1'b0;
   endtask

   // mode 0: ready high, 1: alternate 0/1, 2: random. Negative hold/pulse/abort disables that corner.
   task automatic run_frame(input int mode, input int hold_at, input int pulse_at, input int abort_at);
      logic [DATA_W-1:0] exp_q [$];
      logic [DATA_W-1:0] d;
      logic v, l, rdy;
      int edges = 0;
      int xfers = 0;
      int pulses = 0;
      int hold_left = 5;
      bit seen_done = 0;
      bit aborted = 0;
      bit pulsed = 0;
      for (int k = 0; k < N_POINTS; k++) exp_q.push_back(mem[brev(k)]);
      while (!seen_done && !aborted && edges < BUDGET) begin
         case (mode)
            1:       rdy = (edges % 2 == 1);
            2:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b1;
         endcase
         if (hold_at == xfers && out_bus.out_valid && hold_left > 0) begin
            rdy = 1'b0;
            hold_left--;
         end
         start_strobe = (edges == 0);
         if (pulse_at == xfers && !pulsed && edges > 0) begin
            start_strobe = 1'b1;
            pulsed = 1;
         end
         out_bus.out_ready = rdy;
         v = out_bus.out_valid;
         d = out_bus.out_data;
         l = out_bus.out_last;
         @(posedge tb_clk);
         #1;
         edges++;
         if (v && rdy) begin
            if (exp_q.size() == 0) begin
               check("xfer_limit", xfers, N_POINTS - 1);
            end else begin
               check($sformatf("data%0d", xfers), d, exp_q.pop_front());
               check($sformatf("last%0d", xfers), l, exp_q.size() == 0);
            end
            xfers++;
         end else if (v) begin
            check("hold_valid", out_bus.out_valid, 1);
            check("hold_data", out_bus.out_data, d);
            check("hold_last", out_bus.out_last, l);
            check("hold_rd_en", rd_en, 0);
         end
         if (rd_en) begin
            check($sformatf("rd_addr%0d", pulses), rd_addr, brev(pulses));
            pulses++;
         end else begin
            check("addr_idle", rd_addr, 0);
         end
         check("count", count, xfers);
         if (done_strobe) begin
            seen_done = 1;
            check("done_busy", busy, 0);
            check("done_xfers", xfers, N_POINTS);
            if (mode == 0 && hold_at < 0) check("done_cycle", edges, 2 * N_POINTS + 1);
         end else begin
            check("busy", busy, 1);
         end
         if (abort_at >= 0 && xfers == abort_at) begin
            start_strobe      = 1'b0;
            out_bus.out_ready = 1'b0;
            mid_cycle_reset("abort");
            aborted = 1;
         end
      end
      start_strobe = 1'b0;
      if (!aborted) begin
         check("frame_done_seen", seen_done, 1);
         check("rd_pulses", pulses, N_POINTS);
         for (int i = 0; i < 3; i++) begin
            out_bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge tb_clk);
            #1;
            check("post_done_strobe", done_strobe, 0);
            check("post_state", state_dbg, IDLE);
            check("count_hold", count, N_POINTS);
            check("post_busy", busy, 0);
         end
      end
   endtask

   initial begin
      reset             = 1'b1;
      start_strobe      = 1'b0;
      out_bus.out_ready = 1'b0;
      fill_mem();
      repeat (3) @(posedge tb_clk);
      #1 check_zero("reset");
      reset = 1'b0;
      @(posedge tb_clk);
      #1 check_zero("post_reset");

      run_table();
      mid_cycle_reset("table_end");

      run_frame(0, -1, -1, -1);
      run_frame(0, 3, 10, -1);
      run_frame(1, -1, -1, -1);
      run_frame(0, -1, -1, 20);
      run_frame(0, -1, -1, -1);
      for (int f = 0; f < 4; f++) begin
         fill_mem();
         run_frame(2, -1, -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
